// File: rtl/mac_array_sched_pkg.sv
// Shared definitions for the MAC array sequencer: sizes, FSM states and
// helpers for slicing and sign-extending partial sums.
package mac_array_sched_pkg;

    localparam int NF     = 40;
    localparam int PSUM_W = 22;
    localparam int CG_W   = 8;
    localparam int ACC_W  = 30;
    localparam int PIX_W  = 16;
    localparam int ADDR_W = 16;
    localparam int FILT_W = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Partial sum of filter f; filter 0 occupies the LSBs.
    function automatic logic [PSUM_W-1:0] psum_slice(input logic [NF*PSUM_W-1:0] sums,
                                                     input int unsigned f);
        return sums[f*PSUM_W +: PSUM_W];
    endfunction

    // Sign-extend a partial sum to accumulator width.
    function automatic logic [ACC_W-1:0] psum_sext(input logic [PSUM_W-1:0] p);
        return {{(ACC_W-PSUM_W){p[PSUM_W-1]}}, p};
    endfunction

endpackage

// File: rtl/mac_array_sched_acc_bank.sv
// NF signed accumulators; the first return of a pixel overwrites, later
// returns add. A read mux exposes one accumulator, 0 when out of range.
module sched_acc_bank
    import mac_array_sched_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clr_first_i,
    input  logic                   add_i,
    input  logic [NF*PSUM_W-1:0]   mac_sum_i,
    input  logic [FILT_W-1:0]      rd_sel_i,
    output logic [ACC_W-1:0]       rd_data_o
);

    logic [ACC_W-1:0] acc_q [NF];
    logic [ACC_W-1:0] acc_d [NF];

    // Next accumulator values: load on first return, add on later ones.
    always_comb begin
        for (int f = 0; f < NF; f++) begin
            if (clr_first_i) begin
                acc_d[f] = psum_sext(psum_slice(mac_sum_i, f));
            end else if (add_i) begin
                acc_d[f] = acc_q[f] + psum_sext(psum_slice(mac_sum_i, f));
            end else begin
                acc_d[f] = acc_q[f];
            end
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int f = 0; f < NF; f++) acc_q[f] <= '0;
        end else begin
            for (int f = 0; f < NF; f++) acc_q[f] <= acc_d[f];
        end
    end

    // Read mux for the output stream.
    always_comb begin
        if (rd_sel_i < FILT_W'(NF)) begin
            rd_data_o = acc_q[rd_sel_i];
        end else begin
            rd_data_o = '0;
        end
    end

endmodule

// File: rtl/mac_array_sched.sv
// Sequencer for the 40-filter MAC array: reads every channel group of a
// pixel, issues it to the array, accumulates the returns and streams the
// 40 finished sums out one filter per beat.
module mac_array_sched
    import mac_array_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [CG_W-1:0]       cfg_num_cg,
    input  logic [PIX_W-1:0]      cfg_num_pix,
    input  logic [ADDR_W-1:0]     cfg_fbase,
    input  logic [ADDR_W-1:0]     cfg_wbase,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  fbuf_rd_en,
    output logic [ADDR_W-1:0]     fbuf_rd_addr,
    output logic                  wbuf_rd_en,
    output logic [ADDR_W-1:0]     wbuf_rd_addr,
    output logic                  mac_issue,
    input  logic                  mac_vld,
    input  logic [NF*PSUM_W-1:0]  mac_sum,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [ACC_W-1:0]      out_data,
    output logic [FILT_W-1:0]     out_filt,
    output logic [PIX_W-1:0]      out_pix,
    output logic                  out_last
);

    state_e              state_q, state_d;
    logic                rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d;
    logic                err_q, err_d, mac_issue_q;
    logic [CG_W-1:0]     num_cg_q, num_cg_d, cg_q, cg_d, ret_q, ret_d;
    logic [CG_W:0]       outst_q, outst_d;
    logic [PIX_W-1:0]    num_pix_q, num_pix_d, pix_q, pix_d;
    logic [ADDR_W-1:0]   wbase_q, wbase_d, faddr_q, faddr_d, waddr_q, waddr_d;
    logic                out_vld_q, out_vld_d, out_last_q, out_last_d;
    logic [ACC_W-1:0]    out_data_q, out_data_d, acc_rd_s;
    logic [FILT_W-1:0]   out_filt_q, out_filt_d, acc_sel_s;
    logic                start_ok_s, last_rd_s, vld_ok_s, stray_s, last_ret_s;
    logic                beat_s, last_filt_s, last_pix_s;

    assign start_ok_s  = (state_q == IDLE) && start;
    assign last_rd_s   = rd_en_q && (cg_q == num_cg_q - CG_W'(1));
    assign vld_ok_s    = mac_vld && (outst_q != '0);
    assign stray_s     = mac_vld && (outst_q == '0);
    assign last_ret_s  = vld_ok_s && (ret_q == num_cg_q - CG_W'(1));
    assign beat_s      = out_vld_q && out_rdy;
    assign last_filt_s = (out_filt_q == FILT_W'(NF - 1));
    assign last_pix_s  = (pix_q == num_pix_q - PIX_W'(1));
    // While a beat is shown, prefetch the next filter so it can load on accept.
    assign acc_sel_s   = out_vld_q ? out_filt_q + FILT_W'(1) : out_filt_q;

    sched_acc_bank u_acc_bank (
        .clk         (clk),
        .rstn        (rstn),
        .clr_first_i (vld_ok_s && (ret_q == '0)),
        .add_i       (vld_ok_s && (ret_q != '0)),
        .mac_sum_i   (mac_sum),
        .rd_sel_i    (acc_sel_s),
        .rd_data_o   (acc_rd_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; a zero-sized job goes straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((cfg_num_cg != '0) && (cfg_num_pix != '0)) state_d = ISSUE;
                    else                                           state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE:   state_d = last_rd_s  ? WAIT : ISSUE;
            WAIT:    state_d = last_ret_s ? OUT  : WAIT;
            OUT: begin
                if (beat_s && last_filt_s) state_d = last_pix_s ? DONE : ISSUE;
                else                       state_d = OUT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs, registered from the next state so they align with it.
    always_comb begin
        rd_en_d = (state_d == ISSUE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == DONE);
    end

    // Counters, addresses, error flag and the output beat registers.
    always_comb begin
        num_cg_d   = num_cg_q;   num_pix_d  = num_pix_q;  wbase_d  = wbase_q;
        faddr_d    = faddr_q;    waddr_d    = waddr_q;    cg_d     = cg_q;
        ret_d      = ret_q;      pix_d      = pix_q;      err_d    = err_q;
        out_vld_d  = out_vld_q;  out_data_d = out_data_q; out_filt_d = out_filt_q;
        out_last_d = out_last_q;
        outst_d    = outst_q + (CG_W+1)'(mac_issue_q) - (CG_W+1)'(vld_ok_s);
        if (start_ok_s) begin
            num_cg_d  = cfg_num_cg;  num_pix_d = cfg_num_pix;
            wbase_d   = cfg_wbase;   faddr_d   = cfg_fbase;   waddr_d = cfg_wbase;
            cg_d      = '0;          ret_d     = '0;          pix_d   = '0;
            err_d     = 1'b0;
        end else if (rd_en_q) begin
            // Feature address runs linearly across pixels; weights restart per pixel.
            faddr_d = faddr_q + ADDR_W'(1);
            if (last_rd_s) begin
                cg_d    = '0;
                waddr_d = wbase_q;
            end else begin
                cg_d    = cg_q + CG_W'(1);
                waddr_d = waddr_q + ADDR_W'(1);
            end
        end else begin
            cg_d = cg_q;
        end
        if (vld_ok_s) ret_d = last_ret_s ? '0 : ret_q + CG_W'(1);
        else          ret_d = ret_d;
        if (stray_s)  err_d = 1'b1;
        else          err_d = err_d;
        if (state_q == OUT) begin
            if (!out_vld_q) begin
                out_vld_d  = 1'b1;
                out_data_d = acc_rd_s;
                out_last_d = last_pix_s && last_filt_s;
            end else if (out_rdy) begin
                if (last_filt_s) begin
                    out_vld_d  = 1'b0;  out_data_d = '0;
                    out_filt_d = '0;    out_last_d = 1'b0;
                    pix_d      = last_pix_s ? pix_q : pix_q + PIX_W'(1);
                end else begin
                    out_filt_d = out_filt_q + FILT_W'(1);
                    out_data_d = acc_rd_s;
                    out_last_d = last_pix_s && (out_filt_q == FILT_W'(NF - 2));
                end
            end else begin
                out_vld_d = out_vld_q;
            end
        end else begin
            out_vld_d = out_vld_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_en_q  <= 1'b0; busy_q  <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
            mac_issue_q <= 1'b0;
            num_cg_q <= '0;   num_pix_q <= '0; wbase_q <= '0;
            faddr_q  <= '0;   waddr_q  <= '0;  cg_q    <= '0;  ret_q <= '0;
            outst_q  <= '0;   pix_q    <= '0;
            out_vld_q <= 1'b0; out_data_q <= '0; out_filt_q <= '0; out_last_q <= 1'b0;
        end else begin
            rd_en_q  <= rd_en_d; busy_q  <= busy_d; done_q <= done_d; err_q <= err_d;
            mac_issue_q <= rd_en_q;
            num_cg_q <= num_cg_d; num_pix_q <= num_pix_d; wbase_q <= wbase_d;
            faddr_q  <= faddr_d;  waddr_q  <= waddr_d;  cg_q    <= cg_d;  ret_q <= ret_d;
            outst_q  <= outst_d;  pix_q    <= pix_d;
            out_vld_q <= out_vld_d; out_data_q <= out_data_d;
            out_filt_q <= out_filt_d; out_last_q <= out_last_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign fbuf_rd_en   = rd_en_q;
    assign wbuf_rd_en   = rd_en_q;
    assign fbuf_rd_addr = faddr_q;
    assign wbuf_rd_addr = waddr_q;
    assign mac_issue    = mac_issue_q;
    assign out_vld      = out_vld_q;
    assign out_data     = out_data_q;
    assign out_filt     = out_filt_q;
    assign out_pix      = pix_q;
    assign out_last     = out_last_q;

endmodule

// File: tb/tb_mac_array_sched.sv
// Directed bench for mac_array_sched with a latency-3 model MAC array.
module tb_mac_array_sched;

    localparam int NF = 40;
    localparam int PW = 22;

    logic              clk = 1'b0;
    logic              rstn, start, mac_vld, out_rdy;
    logic [7:0]        cfg_num_cg;
    logic [15:0]       cfg_num_pix, cfg_fbase, cfg_wbase;
    logic              busy, done, err, fbuf_rd_en, wbuf_rd_en, mac_issue;
    logic [15:0]       fbuf_rd_addr, wbuf_rd_addr, out_pix;
    logic [NF*PW-1:0]  mac_sum;
    logic              out_vld, out_last;
    logic [29:0]       out_data;
    logic [5:0]        out_filt;

    // Model array state
    logic              stray_vld = 1'b0;
    logic [3:0]        pv = 4'd0;
    int                pk [4] = '{0, 0, 0, 0};
    int                wbase_m = 0;
    int                mult = 0;
    logic signed [PW-1:0] tab [3];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mac_array_sched dut (
        .clk(clk), .rstn(rstn), .start(start),
        .cfg_num_cg(cfg_num_cg), .cfg_num_pix(cfg_num_pix),
        .cfg_fbase(cfg_fbase), .cfg_wbase(cfg_wbase),
        .busy(busy), .done(done), .err(err),
        .fbuf_rd_en(fbuf_rd_en), .fbuf_rd_addr(fbuf_rd_addr),
        .wbuf_rd_en(wbuf_rd_en), .wbuf_rd_addr(wbuf_rd_addr),
        .mac_issue(mac_issue), .mac_vld(mac_vld), .mac_sum(mac_sum),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .out_filt(out_filt), .out_pix(out_pix), .out_last(out_last)
    );

    // Read strobe -> issue one cycle later -> valid three cycles after issue.
    always @(posedge clk) begin
        pv    <= {pv[2:0], fbuf_rd_en};
        pk[0] <= int'(wbuf_rd_addr) - wbase_m;
        pk[1] <= pk[0];
        pk[2] <= pk[1];
        pk[3] <= pk[2];
    end

    assign mac_vld = pv[3] | stray_vld;

    // Group k returns tab[k%3] + f*mult for filter f.
    always_comb begin
        for (int f = 0; f < NF; f++) begin
            if (stray_vld) mac_sum[f*PW +: PW] = 22'h15555;
            else           mac_sum[f*PW +: PW] = tab[pk[3] % 3] + PW'(f * mult);
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic longint exp_sum(input int cg, input int f);
        longint s = 0;
        for (int k = 0; k < cg; k++) s += longint'(tab[k % 3]) + longint'(f * mult);
        return s;
    endfunction

    task automatic run_job(input int cg, input int pix, input int fb, input int wb, input bit rnd);
        int beat = 0;
        int rd = 0;
        int cyc = 0;
        int nbeats = pix * NF;
        bit seen_done = 1'b0;
        bit stall = 1'b0;
        logic [29:0] hold_d = '0;
        logic [5:0]  hold_f = '0;
        cfg_num_cg = cg[7:0]; cfg_num_pix = pix[15:0];
        cfg_fbase = fb[15:0]; cfg_wbase = wb[15:0]; wbase_m = wb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_cleared", err, 0);
        while (!seen_done && cyc < 5000) begin
            if (fbuf_rd_en) begin
                check("fbuf_addr", fbuf_rd_addr, fb + rd);
                check("wbuf_addr", wbuf_rd_addr, wb + (rd % cg));
                check("wbuf_en", wbuf_rd_en, 1);
                check("no_read_in_out", out_vld, 0);
                rd++;
            end
            if (stall) begin
                check("hold_data", out_data, hold_d);
                check("hold_filt", out_filt, hold_f);
                check("hold_vld", out_vld, 1);
            end
            if (done) begin
                seen_done = 1'b1;
                check("busy_at_done", busy, 0);
            end
            out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stall   = out_vld && !out_rdy;
            hold_d  = out_data;
            hold_f  = out_filt;
            if (out_vld && out_rdy) begin
                check("out_data", longint'($signed(out_data)), exp_sum(cg, beat % NF));
                check("out_filt", out_filt, beat % NF);
                check("out_pix", out_pix, beat / NF);
                check("out_last", out_last, (beat == nbeats - 1) ? 1 : 0);
                beat++;
            end
            // A start while busy, with different config, must be ignored.
            if (cyc == 5) begin
                start = 1'b1; cfg_num_cg = cfg_num_cg + 8'd7;
            end else if (cyc == 6) begin
                start = 1'b0; cfg_num_cg = cg[7:0];
            end
            @(negedge clk);
            cyc++;
        end
        out_rdy = 1'b1;
        check("done_seen", seen_done, 1);
        check("beat_count", beat, nbeats);
        check("read_count", rd, cg * pix);
        check("err_end", err, 0);
    endtask

    initial begin
        bit seen = 1'b0;
        rstn = 1'b0; start = 1'b0; out_rdy = 1'b1;
        cfg_num_cg = 8'd0; cfg_num_pix = 16'd0; cfg_fbase = 16'd0; cfg_wbase = 16'd0;
        tab[0] = 22'sd5; tab[1] = 22'sd5; tab[2] = 22'sd5;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_fbuf_en", fbuf_rd_en, 0);
        check("rst_fbuf_addr", fbuf_rd_addr, 0);
        check("rst_mac_issue", mac_issue, 0);
        check("rst_out_vld", out_vld, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Single group, single pixel: every filter 5.
        mult = 0;
        run_job(1, 1, 0, 0, 1'b0);

        // Three groups, two pixels: -7 + 100 + 1 = 94.
        tab[0] = -22'sd7; tab[1] = 22'sd100; tab[2] = 22'sd1;
        run_job(3, 2, 'h100, 'h20, 1'b0);

        // 255 groups at both extremes of the partial-sum range.
        tab[0] = 22'sh1FFFFF; tab[1] = 22'sh1FFFFF; tab[2] = 22'sh1FFFFF;
        run_job(255, 1, 0, 0, 1'b0);
        tab[0] = 22'sh200000; tab[1] = 22'sh200000; tab[2] = 22'sh200000;
        run_job(255, 1, 0, 0, 1'b0);

        // Zero pixels: busy for one cycle, done the next, no reads.
        cfg_num_cg = 8'd3; cfg_num_pix = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_busy", busy, 1);
        check("zero_done_early", done, 0);
        check("zero_no_read", fbuf_rd_en, 0);
        @(negedge clk);
        check("zero_done", done, 1);
        check("zero_busy_drop", busy, 0);
        check("zero_no_read2", fbuf_rd_en, 0);
        @(negedge clk);
        check("zero_done_pulse", done, 0);

        // Stray return while idle.
        stray_vld = 1'b1;
        @(negedge clk);
        stray_vld = 1'b0;
        check("stray_err", err, 1);
        check("stray_no_out", out_vld, 0);
        check("stray_idle", busy, 0);

        // Per-filter distinct sums with random backpressure; also clears err.
        tab[0] = 22'sd3; tab[1] = -22'sd9; tab[2] = 22'sd11;
        mult = 1000;
        run_job(2, 3, 'h40, 'h8, 1'b1);
        mult = 0;

        // Reset in the middle of ISSUE.
        cfg_num_cg = 8'd10; cfg_num_pix = 16'd1; cfg_fbase = 16'd0; cfg_wbase = 16'd0;
        wbase_m = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_in_issue", fbuf_rd_en, 1);
        rstn = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_fbuf", fbuf_rd_en, 0);
        check("mid_rst_issue", mac_issue, 0);
        check("mid_rst_done", done, 0);
        repeat (6) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("mid_rst_no_done", seen, 0);
        check("mid_rst_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mac_array_sched.md
Name: mac_array_sched

Overview:
- Sequencer for the 40-filter, 36-lane MAC array. Each 36-lane window covers 3x3 pixels by 4 channels.
- For each output pixel it:
  - reads every 4-channel group's window from the feature buffer and the group's 40 filter weight sets from the weight buffer;
  - issues one group per cycle to the array;
  - accumulates the 40 returned partial sums across channel groups;
  - streams the 40 finished sums out one filter per beat over a valid/ready interface.

Parameters:
- NF, 40, filters computed in parallel (number of partial sums per MAC return)
- PSUM_W, 22, signed partial-sum width from the array
- CG_W, 8, channel-group count width (max 255 groups)
- ACC_W, 30, accumulator and output width (PSUM_W+CG_W, never overflows)
- PIX_W, 16, pixel count width
- ADDR_W, 16, buffer address width

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle job start; sampled only in IDLE
- cfg_num_cg  in  CG_W  channel groups per pixel; captured at start
- cfg_num_pix  in  PIX_W  pixels in job; captured at start
- cfg_fbase  in  ADDR_W  feature-buffer base address; captured at start
- cfg_wbase  in  ADDR_W  weight-buffer base address; captured at start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky flag for an unexpected mac_vld; cleared by the next accepted start
- fbuf_rd_en  out  1  feature read strobe; read data valid the next cycle
- fbuf_rd_addr  out  ADDR_W  feature read address
- wbuf_rd_en  out  1  weight read strobe; read data valid the next cycle
- wbuf_rd_addr  out  ADDR_W  weight read address
- mac_issue  out  1  din/weight presented to the array this cycle
- mac_vld  in  1  AND of the array's per-filter valids
- mac_sum  in  NF*PSUM_W  sums concatenated, filter 0 in the LSBs
- out_vld  out  1  result beat valid
- out_rdy  in  1  downstream ready
- out_data  out  ACC_W  accumulated signed sum
- out_filt  out  6  filter index 0..NF-1
- out_pix  out  PIX_W  pixel index
- out_last  out  1  final beat of the job

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; counters and accumulators 0.
  - Reset asserted mid-job aborts immediately with no done pulse.
- IDLE:
  - start with both num_cg and num_pix nonzero: capture config, clear err, set busy, go to ISSUE.
  - start with either count zero: pulse done one cycle later, no reads, busy high for that one cycle.
- ISSUE:
  - Each cycle assert fbuf_rd_en and wbuf_rd_en.
  - fbuf_rd_addr = fbase + linear read count, incrementing across pixels.
  - wbuf_rd_addr = wbase + cg.
  - After num_cg reads, go to WAIT. Back-to-back, no bubbles.
  - mac_issue = fbuf_rd_en delayed one cycle.
- WAIT:
  - Count mac_vld returns.
  - Return k==0: acc[f] = sext(sum_f).
  - Return k>0: acc[f] += sext(sum_f).
  - Returns may arrive while still in ISSUE and are counted identically.
  - After the num_cg-th return, go to OUT.
  - mac_vld with outstanding issues == 0 is ignored and sets err.
- OUT:
  - Present acc[out_filt], starting at out_filt=0.
  - Advance on out_vld && out_rdy.
  - out_rdy low holds all out_* stable.
  - Beat at filter NF-1:
    - if the pixel is not the last: pixel++, go to ISSUE;
    - if the pixel is the last: out_last=1 on that beat, then DONE.
- DONE: done=1 for one cycle, busy drops in the same cycle, return to IDLE.
- start while busy is ignored.
- Pixels do not overlap: no reads are issued during OUT.

Decomposition:
- Shared package: NF, PSUM_W, ACC_W, the state enum (IDLE, ISSUE, WAIT, OUT, DONE), and a function to slice filter f from mac_sum.
- One sub-module, sched_acc_bank: NF accumulators plus the output mux, with clear-on-first and add controls.
- FSM, counters and address generation stay in the top.

Test Plan:
- num_cg=1, num_pix=1, all sums 5 from a model array with latency 3 -> 40 beats of out_data=5, out_filt 0..39, out_last on beat 39, then done.
- num_cg=3, num_pix=2, fbase=0x100, wbase=0x20 -> fbuf addresses 0x100..0x105, wbuf addresses 0x20..0x22 twice; sums [-7,100,1] accumulate to 94 for every filter.
- num_cg=255, every sum = 0x1FFFFF (max positive) -> out_data=534773505 with no wrap; every sum = 0x200000 -> -534773760.
- Random out_rdy backpressure (50%) during OUT -> data held stable while stalled; no beat lost or duplicated.
- num_pix=0 -> done pulses 2 cycles after start with no reads; a start issued while busy has no effect.
- Stray mac_vld in IDLE -> err=1 and accumulators unchanged; rstn low mid-ISSUE -> all outputs 0 and no done pulse.
